// File: rtl/controlador_ajuste_fecha_pkg.sv
// Shared definitions for the date/time setting sequencer: state codes
// (equal to the campo codes), strobe bit positions and small helpers.
package controlador_ajuste_fecha_pkg;

    localparam int NUM_CAMPOS = 5;

    // State encoding doubles as the campo output code.
    typedef enum logic [2:0] {
        REPOSO  = 3'd0,
        AJ_DIA  = 3'd1,
        AJ_MES  = 3'd2,
        AJ_ANIO = 3'd3,
        AJ_HORA = 3'd4,
        AJ_MIN  = 3'd5
    } estado_t;

    // Strobe bit indices inside inc_campo / dec_campo.
    localparam int BIT_DIA  = 0;
    localparam int BIT_MES  = 1;
    localparam int BIT_ANIO = 2;
    localparam int BIT_HORA = 3;
    localparam int BIT_MIN  = 4;

    // One-hot strobe mask for the field edited in a given state.
    function automatic logic [NUM_CAMPOS-1:0] mascara_campo(estado_t e);
        logic [NUM_CAMPOS-1:0] m;
        m = '0;
        case (e)
            AJ_DIA:  m[BIT_DIA]  = 1'b1;
            AJ_MES:  m[BIT_MES]  = 1'b1;
            AJ_ANIO: m[BIT_ANIO] = 1'b1;
            AJ_HORA: m[BIT_HORA] = 1'b1;
            AJ_MIN:  m[BIT_MIN]  = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    // Mode-button sequence, wrapping back to run mode after the minute field.
    function automatic estado_t siguiente_estado(estado_t e);
        case (e)
            REPOSO:  return AJ_DIA;
            AJ_DIA:  return AJ_MES;
            AJ_MES:  return AJ_ANIO;
            AJ_ANIO: return AJ_HORA;
            AJ_HORA: return AJ_MIN;
            default: return REPOSO;
        endcase
    endfunction

endpackage

// File: rtl/controlador_ajuste_fecha_generador_repeticion.sv
// Press detection and auto-repeat for one button. 'disparo' is the
// combinational request for a strobe this cycle; the top registers it.
// 'bloqueo' suppresses requests and drops any repeat in progress.
module generador_repeticion #(
    parameter int DELAY_REPETICION   = 50000000,
    parameter int PERIODO_REPETICION = 10000000,
    parameter int ANCHO_CONT         = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic boton,
    input  logic bloqueo,
    output logic disparo
);

    localparam logic [ANCHO_CONT-1:0] UMBRAL_INI = ANCHO_CONT'(DELAY_REPETICION - 1);
    localparam logic [ANCHO_CONT-1:0] UMBRAL_REP = ANCHO_CONT'(PERIODO_REPETICION - 1);

    logic                  hist_q;
    logic                  act_q, act_d;
    logic                  rep_q, rep_d;
    logic [ANCHO_CONT-1:0] cnt_q, cnt_d;
    logic                  pulsa;
    logic [ANCHO_CONT-1:0] umbral;

    assign pulsa  = boton & ~hist_q;
    assign umbral = rep_q ? UMBRAL_REP : UMBRAL_INI;

    // Hold counter: first repeat after the initial delay, then every period.
    // act_q marks a hold that began with an accepted press.
    always_comb begin
        disparo = 1'b0;
        act_d   = act_q;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        if (bloqueo || !boton) begin
            act_d = 1'b0;
            rep_d = 1'b0;
            cnt_d = '0;
        end else if (pulsa) begin
            disparo = 1'b1;
            act_d   = 1'b1;
            rep_d   = 1'b0;
            cnt_d   = '0;
        end else if (act_q) begin
            if (cnt_q == umbral) begin
                disparo = 1'b1;
                rep_d   = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + ANCHO_CONT'(1);
            end
        end
    end

    // History resets to 1 so a button held through reset needs a release first.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= 1'b1;
            act_q  <= 1'b0;
            rep_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= boton;
            act_q  <= act_d;
            rep_q  <= rep_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/controlador_ajuste_fecha.sv
// Setting-mode sequencer: mode FSM over the five calendar fields, idle
// timeout, arbitration between the two buttons and steering of the
// registered inc/dec strobes to the selected field counter.
module controlador_ajuste_fecha
    import controlador_ajuste_fecha_pkg::*;
#(
    parameter int DELAY_REPETICION   = 50000000,
    parameter int PERIODO_REPETICION = 10000000,
    parameter int TIMEOUT            = 1000000000,
    parameter int ANCHO_CONT         = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  boton_modo,
    input  logic                  boton_aumenta,
    input  logic                  boton_disminuye,
    output logic                  ajuste_activo,
    output logic [2:0]            campo,
    output logic [NUM_CAMPOS-1:0] inc_campo,
    output logic [NUM_CAMPOS-1:0] dec_campo
);

    localparam logic [ANCHO_CONT-1:0] IDLE_MAX = ANCHO_CONT'(TIMEOUT - 1);

    estado_t               estado_q, estado_d;
    logic                  activo_q;
    logic                  modo_hist_q;
    logic [ANCHO_CONT-1:0] idle_q, idle_d;
    logic                  bloqueo_q, bloqueo_d;
    logic [NUM_CAMPOS-1:0] inc_q, inc_d, dec_q, dec_d;
    logic                  modo_pulsa, ambos, alguno, vence, bloqueo_gen;
    logic                  disp_aum, disp_dis;

    assign modo_pulsa = boton_modo & ~modo_hist_q;
    assign ambos      = boton_aumenta & boton_disminuye;
    assign alguno     = boton_modo | boton_aumenta | boton_disminuye;
    assign vence      = (estado_q != REPOSO) && (idle_q == IDLE_MAX);

    // Strobes are blocked outside setting states, on a mode press or
    // timeout edge, on a double press, and while a lock is pending.
    assign bloqueo_gen = bloqueo_q | ambos | modo_pulsa | vence | (estado_q == REPOSO);

    generador_repeticion #(
        .DELAY_REPETICION  (DELAY_REPETICION),
        .PERIODO_REPETICION(PERIODO_REPETICION),
        .ANCHO_CONT        (ANCHO_CONT)
    ) u_rep_aum (
        .clk    (clk),
        .reset  (reset),
        .boton  (boton_aumenta),
        .bloqueo(bloqueo_gen),
        .disparo(disp_aum)
    );

    generador_repeticion #(
        .DELAY_REPETICION  (DELAY_REPETICION),
        .PERIODO_REPETICION(PERIODO_REPETICION),
        .ANCHO_CONT        (ANCHO_CONT)
    ) u_rep_dis (
        .clk    (clk),
        .reset  (reset),
        .boton  (boton_disminuye),
        .bloqueo(bloqueo_gen),
        .disparo(disp_dis)
    );

    // Next state, idle counter, button lock and strobe steering.
    always_comb begin
        estado_d  = estado_q;
        idle_d    = idle_q;
        bloqueo_d = bloqueo_q;
        inc_d     = '0;
        dec_d     = '0;
        if (estado_q == REPOSO) begin
            idle_d = '0;
            if (modo_pulsa) estado_d = AJ_DIA;
        end else if (vence) begin
            estado_d = REPOSO;
            idle_d   = '0;
        end else begin
            if (modo_pulsa) estado_d = siguiente_estado(estado_q);
            idle_d = alguno ? '0 : idle_q + ANCHO_CONT'(1);
        end
        if (ambos || (modo_pulsa && (boton_aumenta || boton_disminuye)))
            bloqueo_d = 1'b1;
        if (!boton_aumenta && !boton_disminuye)
            bloqueo_d = 1'b0;
        if (disp_aum) inc_d = mascara_campo(estado_q);
        if (disp_dis) dec_d = mascara_campo(estado_q);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q    <= REPOSO;
            activo_q    <= 1'b0;
            modo_hist_q <= 1'b1;
            idle_q      <= '0;
            bloqueo_q   <= 1'b0;
            inc_q       <= '0;
            dec_q       <= '0;
        end else begin
            estado_q    <= estado_d;
            activo_q    <= (estado_d != REPOSO);
            modo_hist_q <= boton_modo;
            idle_q      <= idle_d;
            bloqueo_q   <= bloqueo_d;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
        end
    end

    assign campo         = estado_q;
    assign ajuste_activo = activo_q;
    assign inc_campo     = inc_q;
    assign dec_campo     = dec_q;

endmodule

// File: tb/tb_controlador_ajuste_fecha.sv
// Bench for the setting-mode sequencer with short repeat/timeout constants.
module tb_controlador_ajuste_fecha;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       boton_modo = 1'b0;
    logic       boton_aumenta = 1'b0;
    logic       boton_disminuye = 1'b0;
    logic       ajuste_activo;
    logic [2:0] campo;
    logic [4:0] inc_campo, dec_campo;

    controlador_ajuste_fecha #(
        .DELAY_REPETICION  (4),
        .PERIODO_REPETICION(2),
        .TIMEOUT           (20),
        .ANCHO_CONT        (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .boton_modo     (boton_modo),
        .boton_aumenta  (boton_aumenta),
        .boton_disminuye(boton_disminuye),
        .ajuste_activo  (ajuste_activo),
        .campo          (campo),
        .inc_campo      (inc_campo),
        .dec_campo      (dec_campo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, m, a, d;
        logic [2:0] campo;
        logic [4:0] inc, dec;
    } vec_t;

    vec_t  exp_q[$];
    vec_t  tbl[20];
    int    total = 0;
    int    bad = 0;
    int    paso = 0;
    string nombre = "";

    // Pop the expectation for the edge just taken and compare all outputs.
    task automatic comprobar();
        vec_t e;
        logic act_exp;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s step %0d: scoreboard empty", nombre, paso);
            return;
        end
        e = exp_q.pop_front();
        act_exp = (e.campo != 3'd0);
        if (campo !== e.campo || ajuste_activo !== act_exp ||
            inc_campo !== e.inc || dec_campo !== e.dec) begin
            bad++;
            $display("FAIL %s step %0d: got campo=%0d act=%0b inc=%b dec=%b, expected campo=%0d act=%0b inc=%b dec=%b",
                     nombre, paso, campo, ajuste_activo, inc_campo, dec_campo,
                     e.campo, act_exp, e.inc, e.dec);
        end
        total++;
        if ($countones(inc_campo | dec_campo) > 1) begin
            bad++;
            $display("FAIL %s step %0d onehot: got inc=%b dec=%b, expected at most one bit",
                     nombre, paso, inc_campo, dec_campo);
        end
        paso++;
    endtask

    task automatic aplicar(input vec_t v);
        reset           = v.rst;
        boton_modo      = v.m;
        boton_aumenta   = v.a;
        boton_disminuye = v.d;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        comprobar();
    endtask

    task automatic s(input logic rst, input logic m, input logic a, input logic d,
                     input logic [2:0] c, input logic [4:0] inc, input logic [4:0] dec);
        vec_t v;
        v.rst = rst; v.m = m; v.a = a; v.d = d;
        v.campo = c; v.inc = inc; v.dec = dec;
        aplicar(v);
    endtask

    task automatic seccion(input string n);
        nombre = n;
        paso = 0;
    endtask

    initial begin
        // Mode cycling, single steps in AJ_MES, presses ignored in REPOSO.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 5'b00000};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 5'b00000};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 5'b00000, 5'b00000};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 5'b00000, 5'b00000};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 5'b00000, 5'b00000};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 5'b00000, 5'b00000};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 5'b00010, 5'b00000};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 5'b00000, 5'b00000};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 5'b00000, 5'b00010};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 5'b00000, 5'b00000};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 5'b00000, 5'b00000};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 5'b00000, 5'b00000};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 5'b00000, 5'b00000};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 5'b00000, 5'b00000};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 5'b00000, 5'b00000};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 5'b00000, 5'b00000};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'b00000, 5'b00000};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 5'b00000};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 5'b00000, 5'b00000};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 5'b00000};

        @(posedge clk);
        #1;
        seccion("table");
        for (int i = 0; i < 20; i++) aplicar(tbl[i]);

        // Auto-repeat in AJ_DIA: strobes at 0,4,6,8,10 after the press.
        seccion("repeat");
        s(0, 1, 0, 0, 3'd1, 5'b0, 5'b0);
        s(0, 0, 0, 0, 3'd1, 5'b0, 5'b0);
        for (int k = 0; k < 11; k++)
            s(0, 0, 1, 0, 3'd1, (k == 0 || k == 4 || k == 6 || k == 8 || k == 10) ? 5'b00001 : 5'b0, 5'b0);
        for (int k = 0; k < 4; k++) s(0, 0, 0, 0, 3'd1, 5'b0, 5'b0);

        // Both buttons together, then one released first: silent until a clean press.
        seccion("both");
        for (int k = 0; k < 5; k++) s(0, 0, 1, 1, 3'd1, 5'b0, 5'b0);
        for (int k = 0; k < 6; k++) s(0, 0, 0, 1, 3'd1, 5'b0, 5'b0);
        s(0, 0, 0, 0, 3'd1, 5'b0, 5'b0);
        s(0, 0, 1, 0, 3'd1, 5'b00001, 5'b0);
        s(0, 0, 0, 0, 3'd1, 5'b0, 5'b0);

        // Mode and aumenta on the same edge: field advances, held button stays locked.
        seccion("modo_aum");
        s(0, 1, 1, 0, 3'd2, 5'b0, 5'b0);
        for (int k = 0; k < 6; k++) s(0, 0, 1, 0, 3'd2, 5'b0, 5'b0);
        s(0, 0, 0, 0, 3'd2, 5'b0, 5'b0);
        s(0, 0, 1, 0, 3'd2, 5'b00010, 5'b0);
        s(0, 0, 0, 0, 3'd2, 5'b0, 5'b0);

        // Timeout in AJ_HORA, restarted by a press at idle cycle 19.
        seccion("timeout");
        s(0, 1, 0, 0, 3'd3, 5'b0, 5'b0);
        s(0, 0, 0, 0, 3'd3, 5'b0, 5'b0);
        s(0, 1, 0, 0, 3'd4, 5'b0, 5'b0);
        for (int k = 1; k <= 18; k++) s(0, 0, 0, 0, 3'd4, 5'b0, 5'b0);
        s(0, 0, 1, 0, 3'd4, 5'b01000, 5'b0);
        for (int k = 1; k <= 19; k++) s(0, 0, 0, 0, 3'd4, 5'b0, 5'b0);
        s(0, 0, 0, 0, 3'd0, 5'b0, 5'b0);
        s(0, 0, 0, 0, 3'd0, 5'b0, 5'b0);

        // aumenta held through reset: ignored until released and pressed again.
        seccion("held_reset");
        s(1, 0, 1, 0, 3'd0, 5'b0, 5'b0);
        s(1, 0, 1, 0, 3'd0, 5'b0, 5'b0);
        s(0, 0, 1, 0, 3'd0, 5'b0, 5'b0);
        s(0, 1, 1, 0, 3'd1, 5'b0, 5'b0);
        for (int k = 0; k < 6; k++) s(0, 0, 1, 0, 3'd1, 5'b0, 5'b0);
        s(0, 0, 0, 0, 3'd1, 5'b0, 5'b0);
        s(0, 0, 1, 0, 3'd1, 5'b00001, 5'b0);
        s(0, 0, 0, 0, 3'd1, 5'b0, 5'b0);

        // Reset in AJ_ANIO at the first repeat instant: no strobe, back to REPOSO.
        seccion("reset_mid");
        s(0, 1, 0, 0, 3'd2, 5'b0, 5'b0);
        s(0, 0, 0, 0, 3'd2, 5'b0, 5'b0);
        s(0, 1, 0, 0, 3'd3, 5'b0, 5'b0);
        s(0, 0, 0, 0, 3'd3, 5'b0, 5'b0);
        s(0, 0, 1, 0, 3'd3, 5'b00100, 5'b0);
        for (int k = 1; k <= 3; k++) s(0, 0, 1, 0, 3'd3, 5'b0, 5'b0);
        s(1, 0, 1, 0, 3'd0, 5'b0, 5'b0);
        s(0, 0, 0, 0, 3'd0, 5'b0, 5'b0);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
